uart_rx_ctrl: RTL and testbench

- Control and buffering wrapper that sequences the UART receive datapath.
- Holds the receiver's live configuration (prescale, PAR_EN, PAR_TYP) and applies host update requests only after the serial line has been idle for a programmable number of bit times, then flushes the receiver through a local reset.
- Buffers received bytes (P_data/data_valid) in a small FIFO with a ready/valid output and a sticky overflow flag.
- Sits between the host/config logic and the UART_RX instance.

---
 rtl/uart_rx_ctrl_if.sv | 20 ++
 rtl/uart_rx_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Byte stream leaving the receive buffer: show-ahead data with a ready/valid handshake.
interface uart_rx_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Control wrapper around a UART receiver: owns the live configuration, applies
// host updates only once the serial line has been idle long enough, flushes the
// receiver through a two-cycle local reset, and buffers received bytes in a FIFO.
module uart_rx_ctrl #(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int DEPTH          = 4,
    parameter int IDLE_BITS      = 11,
    parameter int DEF_PRESCALE   = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic                      cfg_req,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_par_en,
    input  logic                      cfg_par_typ,
    output logic                      cfg_busy,
    output logic                      cfg_ack,
    output logic                      cfg_err,
    output logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      PAR_EN,
    output logic                      PAR_TYP,
    output logic                      rx_rst_n,
    input  logic [WIDTH-1:0]          rx_data,
    input  logic                      rx_valid,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    input  logic                      ovf_clr,
    uart_rx_ctrl_if.master            out_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = PRESCALE_WIDTH + 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        FLUSH0 = 2'd2,
        FLUSH1 = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic                      latch_s;
    logic                      err_s;
    logic [PRESCALE_WIDTH-1:0] shadow_prescale_r;
    logic                      shadow_par_en_r;
    logic                      shadow_par_typ_r;
    logic [CNT_W-1:0]          idle_cnt_r;
    logic [CNT_W-1:0]          threshold_s;
    logic                      idle_s;

    logic [WIDTH-1:0]          mem_r [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r;
    logic [PTR_W-1:0]          rd_ptr_r;
    logic                      out_valid_r;
    logic                      push_req_s;
    logic                      pop_s;
    logic                      full_s;
    logic                      push_s;
    logic                      drop_s;
    logic [LVL_W-1:0]          level_next_s;

    // Idle threshold scales with the live bit time; full width so it never wraps.
    assign threshold_s = CNT_W'(IDLE_BITS) * CNT_W'(prescale);
    assign idle_s      = (idle_cnt_r == threshold_s);

    // Next-state and request decode for the configuration sequencer.
    always_comb begin
        state_next_s = state_r;
        latch_s      = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            RUN: begin
                if (cfg_req) begin
                    if (cfg_prescale != {PRESCALE_WIDTH{1'b0}}) begin
                        state_next_s = PEND;
                        latch_s      = 1'b1;
                    end else begin
                        err_s        = 1'b1;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            PEND: begin
                if (idle_s) begin
                    state_next_s = FLUSH0;
                end else begin
                    state_next_s = PEND;
                end
            end
            FLUSH0:  state_next_s = FLUSH1;
            FLUSH1:  state_next_s = RUN;
            default: state_next_s = RUN;
        endcase
    end

    // State register plus the registered control outputs derived from next state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r  <= RUN;
            rx_rst_n <= 1'b0;
            cfg_busy <= 1'b0;
            cfg_ack  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            rx_rst_n <= (state_next_s != FLUSH0) && (state_next_s != FLUSH1);
            cfg_busy <= (state_next_s != RUN);
            cfg_ack  <= (state_r == FLUSH1);
            cfg_err  <= err_s;
        end
    end

    // Shadow holds the accepted request; live config copies it on FLUSH0 entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shadow_prescale_r <= PRESCALE_WIDTH'(DEF_PRESCALE);
            shadow_par_en_r   <= 1'b0;
            shadow_par_typ_r  <= 1'b0;
            prescale          <= PRESCALE_WIDTH'(DEF_PRESCALE);
            PAR_EN            <= 1'b0;
            PAR_TYP           <= 1'b0;
        end else begin
            if (latch_s) begin
                shadow_prescale_r <= cfg_prescale;
                shadow_par_en_r   <= cfg_par_en;
                shadow_par_typ_r  <= cfg_par_typ;
            end
            if (state_next_s == FLUSH0) begin
                prescale <= shadow_prescale_r;
                PAR_EN   <= shadow_par_en_r;
                PAR_TYP  <= shadow_par_typ_r;
            end
        end
    end

    // Line-idle counter: any low sample restarts it, and so does a flush so the
    // new bit time is measured from scratch.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (state_next_s == FLUSH0) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (!RX_IN) begin
            idle_cnt_r <= {CNT_W{1'b0}};
        end else if (idle_cnt_r < threshold_s) begin
            idle_cnt_r <= idle_cnt_r + CNT_W'(1);
        end
    end

    // Bytes arriving while the receiver is being flushed are not trusted.
    assign push_req_s = rx_valid && ((state_r == RUN) || (state_r == PEND));
    assign pop_s      = out_valid_r && out_if.out_ready;
    assign full_s     = (fifo_level == LVL_W'(DEPTH));
    assign push_s     = push_req_s && (!full_s || pop_s);
    assign drop_s     = push_req_s && full_s && !pop_s;

    // Occupancy update for the four push/pop combinations.
    always_comb begin
        level_next_s = fifo_level;
        case ({push_s, pop_s})
            2'b10:   level_next_s = fifo_level + LVL_W'(1);
            2'b01:   level_next_s = fifo_level - LVL_W'(1);
            default: level_next_s = fifo_level;
        endcase
    end

    // FIFO storage, pointers, occupancy and the sticky drop flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            fifo_level  <= {LVL_W{1'b0}};
            out_valid_r <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= rx_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            fifo_level  <= level_next_s;
            out_valid_r <= (level_next_s != {LVL_W{1'b0}});
            if (drop_s) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign out_if.out_data  = mem_r[rd_ptr_r];
    assign out_if.out_valid = out_valid_r;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: reset state, idle-gated config apply, request
// rejection, FIFO overflow and ordering, flush-time byte discard, mid-flight reset.
module tb_uart_rx_ctrl;
    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       cfg_req;
    logic [5:0] cfg_prescale;
    logic       cfg_par_en;
    logic       cfg_par_typ;
    logic       cfg_busy;
    logic       cfg_ack;
    logic       cfg_err;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       rx_rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;

    int total_cnt = 0;
    int bad_cnt   = 0;

    uart_rx_ctrl_if #(.WIDTH(8)) out_if ();

    uart_rx_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .cfg_req      (cfg_req),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .cfg_busy     (cfg_busy),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err),
        .prescale     (prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .rx_rst_n     (rx_rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr),
        .out_if       (out_if.master)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int         n;
        logic       ack_seen;

        RST = 1'b0; RX_IN = 1'b1; cfg_req = 1'b0; cfg_prescale = 6'd0;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        ovf_clr = 1'b0; out_if.out_ready = 1'b0;

        // reset state
        #23;
        check_val("rst_rx_rst_n", 32'(rx_rst_n), 32'd0);
        check_val("rst_prescale", 32'(prescale), 32'd8);
        check_val("rst_par_en", 32'(PAR_EN), 32'd0);
        check_val("rst_busy", 32'(cfg_busy), 32'd0);
        check_val("rst_out_valid", 32'(out_if.out_valid), 32'd0);
        check_val("rst_level", 32'(fifo_level), 32'd0);
        #4 RST = 1'b1;
        tick();
        check_val("rel_rx_rst_n", 32'(rx_rst_n), 32'd1);

        // config apply with the line already idle
        repeat (95) tick();
        cfg_req = 1'b1; cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        tick();
        cfg_req = 1'b0;
        check_val("apply_busy", 32'(cfg_busy), 32'd1);
        check_val("apply_pend_rst", 32'(rx_rst_n), 32'd1);
        tick();
        check_val("f0_rx_rst_n", 32'(rx_rst_n), 32'd0);
        check_val("f0_prescale", 32'(prescale), 32'd16);
        check_val("f0_par", 32'({PAR_EN, PAR_TYP}), 32'd3);
        check_val("f0_ack", 32'(cfg_ack), 32'd0);
        tick();
        check_val("f1_rx_rst_n", 32'(rx_rst_n), 32'd0);
        check_val("f1_ack", 32'(cfg_ack), 32'd0);
        tick();
        check_val("run_rx_rst_n", 32'(rx_rst_n), 32'd1);
        check_val("run_ack", 32'(cfg_ack), 32'd1);
        check_val("run_busy", 32'(cfg_busy), 32'd0);
        tick();
        check_val("ack_single", 32'(cfg_ack), 32'd0);

        // request held pending by a busy line; second request ignored
        RX_IN = 1'b0;
        cfg_req = 1'b1; cfg_prescale = 6'd5; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        tick();
        cfg_req = 1'b0;
        check_val("pend_busy", 32'(cfg_busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            RX_IN = 1'b1;
            if (i == 2) begin
                cfg_req = 1'b1; cfg_prescale = 6'd9; cfg_par_en = 1'b1;
                tick();
                cfg_req = 1'b0;
                check_val("pend_no_err", 32'(cfg_err), 32'd0);
                repeat (19) tick();
            end else begin
                repeat (20) tick();
            end
            RX_IN = 1'b0;
            repeat (20) tick();
        end
        check_val("pend_prescale", 32'(prescale), 32'd16);
        check_val("pend_busy2", 32'(cfg_busy), 32'd1);
        check_val("pend_rx_rst_n", 32'(rx_rst_n), 32'd1);
        // 16 * 11 = 176 idle cycles, then one more edge to leave PEND
        RX_IN = 1'b1;
        n = 0;
        while (rx_rst_n !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check_val("idle_wait", 32'(n), 32'd177);
        check_val("pend_apply_prescale", 32'(prescale), 32'd5);
        check_val("pend_apply_par", 32'({PAR_EN, PAR_TYP}), 32'd0);
        tick();
        tick();
        check_val("pend_ack", 32'(cfg_ack), 32'd1);

        // zero prescale rejected
        cfg_req = 1'b1; cfg_prescale = 6'd0; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        tick();
        cfg_req = 1'b0;
        check_val("err_pulse", 32'(cfg_err), 32'd1);
        check_val("err_busy", 32'(cfg_busy), 32'd0);
        tick();
        check_val("err_single", 32'(cfg_err), 32'd0);
        check_val("err_cfg", 32'({prescale, PAR_EN, PAR_TYP}), 32'({6'd5, 2'b00}));

        // overflow: five pushes into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'hA1 + i);
            tick();
        end
        rx_valid = 1'b0;
        check_val("ovf_level", 32'(fifo_level), 32'd4);
        check_val("ovf_flag", 32'(overflow), 32'd1);
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("drain_data", 32'(out_if.out_data), 32'(8'(8'hA1 + i)));
            tick();
        end
        out_if.out_ready = 1'b0;
        check_val("drain_level", 32'(fifo_level), 32'd0);
        check_val("drain_valid", 32'(out_if.out_valid), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("ovf_clr", 32'(overflow), 32'd0);

        // drop with simultaneous clear: set wins
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'(8'hB0 + i);
            tick();
        end
        rx_data = 8'hB4; ovf_clr = 1'b1;
        tick();
        rx_valid = 1'b0; ovf_clr = 1'b0;
        check_val("set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // full with push and pop together
        rx_valid = 1'b1; rx_data = 8'hC0; out_if.out_ready = 1'b1;
        tick();
        rx_valid = 1'b0; out_if.out_ready = 1'b0;
        check_val("pp_level", 32'(fifo_level), 32'd4);
        check_val("pp_ovf", 32'(overflow), 32'd0);
        check_val("pp_head", 32'(out_if.out_data), 32'hB1);
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_val("pp_drain", 32'(out_if.out_data), 32'(exp_q[i]));
            tick();
        end
        out_if.out_ready = 1'b0;
        check_val("pp_empty", 32'(fifo_level), 32'd0);

        // byte arriving during FLUSH0 is discarded (threshold now 55)
        repeat (60) tick();
        cfg_req = 1'b1; cfg_prescale = 6'd8; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        tick();
        cfg_req = 1'b0;
        tick();
        check_val("fl_in_flush", 32'(rx_rst_n), 32'd0);
        rx_valid = 1'b1; rx_data = 8'h77;
        tick();
        rx_valid = 1'b0;
        check_val("fl_level", 32'(fifo_level), 32'd0);
        check_val("fl_valid", 32'(out_if.out_valid), 32'd0);
        tick();
        check_val("fl_ack", 32'(cfg_ack), 32'd1);

        // reset while a request is pending
        RX_IN = 1'b0;
        cfg_req = 1'b1; cfg_prescale = 6'd20;
        tick();
        cfg_req = 1'b0;
        check_val("mr_busy", 32'(cfg_busy), 32'd1);
        RST = 1'b0;
        #1;
        check_val("mr_busy_rst", 32'(cfg_busy), 32'd0);
        check_val("mr_prescale", 32'(prescale), 32'd8);
        check_val("mr_rx_rst_n", 32'(rx_rst_n), 32'd0);
        #2 RST = 1'b1;
        RX_IN = 1'b1;
        tick();
        check_val("mr_rel", 32'(rx_rst_n), 32'd1);
        ack_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ack_seen = ack_seen | cfg_ack | cfg_busy;
            tick();
        end
        check_val("mr_no_ack", 32'(ack_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
